// File: rtl/timer_restart_ctrl.sv
// Timer restart controller: sequences GOJAM restarts, run/stop and
// monitor single-step, advancing only on EVNSET strobes.
module timer_restart_ctrl #(
    parameter int GOJAM_MCT = 4,
    parameter int CNT_W     = 8
) (
    input  logic             SIM_CLK,
    input  logic             RESET_,
    input  logic             EVNSET,
    input  logic             T12,
    input  logic             SBY,
    input  logic             ALGA,
    input  logic             MSTRTP,
    input  logic             STRT1,
    input  logic             STRT2,
    input  logic             GOJ1,
    input  logic             MSTP,
    input  logic             MSTEP,
    output logic             STOP,
    output logic             GOJAM_,
    output logic             STOPA,
    output logic [CNT_W-1:0] RSTCNT
);

    typedef enum logic [1:0] {
        S_GOJAM,
        S_RUN,
        S_HOLD,
        S_STEP
    } state_t;

    localparam logic [3:0]       MCT_LOAD = 4'(GOJAM_MCT - 1);
    localparam logic [3:0]       MCT_ONE  = 4'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       gcnt_q;
    logic [3:0]       gcnt_d;
    logic [CNT_W-1:0] rstcnt_q;
    logic [CNT_W-1:0] rstcnt_d;
    logic             gopend_q;
    logic             gopend_d;
    logic             steppend_q;
    logic             steppend_d;
    logic             mstep_q;
    logic             goset;
    logic             go_take;
    logic             mstep_rise;
    logic             step_take;
    logic             stop_d;
    logic             gojam_n_d;
    logic             stopa_d;

    assign goset      = SBY | ALGA | MSTRTP | STRT1 | STRT2 | GOJ1;
    // A cause arriving on the strobe itself is taken at once.
    assign go_take    = EVNSET & (gopend_q | goset);
    assign mstep_rise = MSTEP & ~mstep_q;

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        rstcnt_d  = rstcnt_q;
        gopend_d  = gopend_q | goset;
        step_take = 1'b0;
        if (EVNSET) begin
            gopend_d = 1'b0;
        end
        if (go_take) begin
            state_d = S_GOJAM;
            gcnt_d  = MCT_LOAD;
            if (rstcnt_q != CNT_MAX) begin
                rstcnt_d = rstcnt_q + CNT_ONE;
            end
        end else if (EVNSET) begin
            unique case (state_q)
                S_GOJAM: begin
                    if (gcnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        gcnt_d = gcnt_q - MCT_ONE;
                    end
                end
                S_RUN: begin
                    if (T12 && MSTP) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!MSTP) begin
                        state_d = S_RUN;
                    end else if (steppend_q) begin
                        state_d   = S_STEP;
                        step_take = 1'b1;
                    end
                end
                S_STEP: begin
                    if (T12) begin
                        state_d = MSTP ? S_HOLD : S_RUN;
                    end
                end
            endcase
        end
    end

    // Step requests only live while held; edges elsewhere are dropped.
    always_comb begin
        steppend_d = steppend_q;
        if (state_q != S_HOLD || step_take) begin
            steppend_d = 1'b0;
        end else if (mstep_rise) begin
            steppend_d = 1'b1;
        end
    end

    always_comb begin
        gojam_n_d = (state_d != S_GOJAM);
        stop_d    = (state_d == S_GOJAM) || (state_d == S_HOLD);
        stopa_d   = (state_d == S_HOLD);
    end

    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q    <= S_GOJAM;
            gcnt_q     <= MCT_LOAD;
            rstcnt_q   <= '0;
            gopend_q   <= 1'b0;
            steppend_q <= 1'b0;
            mstep_q    <= 1'b0;
            GOJAM_     <= 1'b0;
            STOP       <= 1'b1;
            STOPA      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            rstcnt_q   <= rstcnt_d;
            gopend_q   <= gopend_d;
            steppend_q <= steppend_d;
            mstep_q    <= MSTEP;
            GOJAM_     <= gojam_n_d;
            STOP       <= stop_d;
            STOPA      <= stopa_d;
        end
    end

    assign RSTCNT = rstcnt_q;

endmodule

// File: tb/tb_timer_restart_ctrl.sv
// Bench for timer_restart_ctrl: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural model.
module tb_timer_restart_ctrl;

    localparam int MCT  = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic evn = 1'b0;
    logic t12 = 1'b0;
    logic sby = 1'b0;
    logic alga = 1'b0;
    logic mstrtp = 1'b0;
    logic strt1 = 1'b0;
    logic strt2 = 1'b0;
    logic goj1 = 1'b0;
    logic mstp = 1'b0;
    logic mstep = 1'b0;
    logic stop;
    logic gojam_n;
    logic stopa;
    logic [CW-1:0] rstcnt;

    int n_tests = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Model: 0 restart, 1 run, 2 hold, 3 step
    int m_mode = 0;
    int m_left = MCT;
    int m_rst = 0;
    bit m_pend = 1'b0;
    bit m_stepreq = 1'b0;
    bit m_prev = 1'b0;
    bit m_go;
    bit m_edge;
    bit m_took;
    int m_old;

    timer_restart_ctrl #(
        .GOJAM_MCT(MCT),
        .CNT_W    (CW)
    ) dut (
        .SIM_CLK(clk),
        .RESET_ (rst_n),
        .EVNSET (evn),
        .T12    (t12),
        .SBY    (sby),
        .ALGA   (alga),
        .MSTRTP (mstrtp),
        .STRT1  (strt1),
        .STRT2  (strt2),
        .GOJ1   (goj1),
        .MSTP   (mstp),
        .MSTEP  (mstep),
        .STOP   (stop),
        .GOJAM_ (gojam_n),
        .STOPA  (stopa),
        .RSTCNT (rstcnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0;
            m_left = MCT;
            m_rst = 0;
            m_pend = 1'b0;
            m_stepreq = 1'b0;
            m_prev = 1'b0;
        end else begin
            m_go = sby | alga | mstrtp | strt1 | strt2 | goj1;
            m_edge = mstep && !m_prev;
            m_prev = mstep;
            m_old = m_mode;
            m_took = 1'b0;
            if (evn) begin
                if (m_pend || m_go) begin
                    m_mode = 0;
                    m_left = MCT;
                    if (m_rst < CMAX) m_rst++;
                end else begin
                    case (m_mode)
                        0: begin
                            m_left--;
                            if (m_left == 0) m_mode = 1;
                        end
                        1: if (t12 && mstp) m_mode = 2;
                        2: begin
                            if (!mstp) m_mode = 1;
                            else if (m_stepreq) begin
                                m_mode = 3;
                                m_took = 1'b1;
                            end
                        end
                        default: if (t12) m_mode = mstp ? 2 : 1;
                    endcase
                end
                m_pend = 1'b0;
            end else begin
                m_pend = m_pend | m_go;
            end
            if (m_old != 2 || m_took) m_stepreq = 1'b0;
            else if (m_edge) m_stepreq = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cyc_gojam_n", 32'(gojam_n), 32'(m_mode != 0));
            chk("cyc_stop", 32'(stop), 32'(m_mode == 0 || m_mode == 2));
            chk("cyc_stopa", 32'(stopa), 32'(m_mode == 2));
            chk("cyc_rstcnt", 32'(rstcnt), 32'(m_rst));
        end
    end

    task automatic cyc(input bit e);
        evn = e;
        @(posedge clk);
        #2;
        evn = 1'b0;
    endtask

    task automatic memcyc(input int n);
        repeat (n - 1) cyc(1'b0);
        cyc(1'b1);
    endtask

    initial begin
        int per;
        int k;
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        repeat (3) cyc(1'b0);
        chk("rst_gojam_n", 32'(gojam_n), 32'd0);
        chk("rst_stop", 32'(stop), 32'd1);
        chk("rst_stopa", 32'(stopa), 32'd0);
        chk("rst_rstcnt", 32'(rstcnt), 32'd0);
        rst_n = 1'b1;

        // Power-on restart runs MCT strobes
        repeat (MCT - 1) memcyc(12);
        chk("por_still_gojam", 32'(gojam_n), 32'd0);
        memcyc(12);
        chk("por_gojam_n", 32'(gojam_n), 32'd1);
        chk("por_stop", 32'(stop), 32'd0);
        chk("por_rstcnt", 32'(rstcnt), 32'd0);

        // Short STRT1 pulse latched until strobe
        repeat (3) cyc(1'b0);
        strt1 = 1'b1;
        cyc(1'b0);
        strt1 = 1'b0;
        memcyc(8);
        chk("strt1_gojam_n", 32'(gojam_n), 32'd0);
        chk("strt1_rstcnt", 32'(rstcnt), 32'd1);

        // ALGA on second GOJAM strobe reloads
        memcyc(12);
        repeat (11) cyc(1'b0);
        alga = 1'b1;
        cyc(1'b1);
        alga = 1'b0;
        chk("alga_rstcnt", 32'(rstcnt), 32'd2);
        repeat (MCT - 1) memcyc(12);
        chk("alga_still_gojam", 32'(gojam_n), 32'd0);
        memcyc(12);
        chk("alga_run", 32'(gojam_n), 32'd1);

        // Monitor stop at instruction boundary, then single step
        mstp = 1'b1;
        repeat (2) memcyc(12);
        chk("mstp_no_t12", 32'(stop), 32'd0);
        repeat (11) cyc(1'b0);
        t12 = 1'b1;
        cyc(1'b1);
        t12 = 1'b0;
        chk("hold_stop", 32'(stop), 32'd1);
        chk("hold_stopa", 32'(stopa), 32'd1);
        mstep = 1'b1;
        repeat (2) cyc(1'b0);
        mstep = 1'b0;
        memcyc(10);
        chk("step_stop", 32'(stop), 32'd0);
        chk("step_stopa", 32'(stopa), 32'd0);
        memcyc(12);
        chk("step_no_t12", 32'(stop), 32'd0);
        repeat (11) cyc(1'b0);
        t12 = 1'b1;
        cyc(1'b1);
        t12 = 1'b0;
        chk("step_back_hold", 32'(stopa), 32'd1);

        // Restart beats release from HOLD
        mstp = 1'b0;
        strt2 = 1'b1;
        cyc(1'b0);
        strt2 = 1'b0;
        memcyc(11);
        chk("hold_go_gojam", 32'(gojam_n), 32'd0);
        chk("hold_go_rstcnt", 32'(rstcnt), 32'd3);
        repeat (MCT) memcyc(12);
        chk("hold_go_run", 32'(stop), 32'd0);

        // Randomized traffic
        per = $urandom_range(2, 12);
        k = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) mstp = ~mstp;
            if ($urandom_range(0, 5) == 0) mstep = ~mstep;
            t12 = ($urandom_range(0, 2) == 0);
            {sby, alga, mstrtp, strt1, strt2, goj1} =
                ($urandom_range(0, 59) == 0) ?
                6'(1 << $urandom_range(0, 5)) : 6'd0;
            k++;
            if (k >= per) begin
                cyc(1'b1);
                k = 0;
                per = $urandom_range(2, 12);
            end else begin
                cyc(1'b0);
            end
        end
        {sby, alga, mstrtp, strt1, strt2, goj1} = 6'd0;
        {t12, mstp, mstep} = 3'd0;

        // Counter saturation
        strt1 = 1'b1;
        repeat (300) memcyc(2);
        strt1 = 1'b0;
        chk("sat_rstcnt", 32'(rstcnt), 32'd255);
        repeat (MCT) memcyc(2);
        chk("sat_run", 32'(gojam_n), 32'd1);
        chk("sat_hold_cnt", 32'(rstcnt), 32'd255);

        // Async reset while stepping
        mstp = 1'b1;
        t12 = 1'b1;
        memcyc(3);
        t12 = 1'b0;
        mstep = 1'b1;
        cyc(1'b0);
        mstep = 1'b0;
        memcyc(3);
        chk("pre_rst_step", 32'(stop), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_gojam_n", 32'(gojam_n), 32'd0);
        chk("arst_stop", 32'(stop), 32'd1);
        chk("arst_stopa", 32'(stopa), 32'd0);
        chk("arst_rstcnt", 32'(rstcnt), 32'd0);
        repeat (2) cyc(1'b0);
        rst_n = 1'b1;
        repeat (MCT) memcyc(4);
        chk("arst_run", 32'(gojam_n), 32'd1);
        chk("arst_run_cnt", 32'(rstcnt), 32'd0);
        cyc(1'b0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_restart_ctrl.md
TIMER_RESTART_CTRL -- requirements
Module: timer_restart_ctrl

Interface
REQ-001 Parameter GOJAM_MCT, default 4, meaning number of EVNSET strobes for which GOJAM_ is held low per restart (legal 1..15).
REQ-002 Parameter CNT_W, default 8, meaning width of the restart event counter RSTCNT.
REQ-003 SIM_CLK  in  1  single system clock; all state changes on its rising edge.
REQ-004 RESET_  in  1  asynchronous, active-low reset.
REQ-005 EVNSET  in  1  timer even-set strobe, high for exactly one SIM_CLK cycle per memory cycle; the only timer advance point.
REQ-006 T12  in  1  end-of-instruction indicator, sampled only when EVNSET=1.
REQ-007 SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1  in  1 each  restart causes, active high, level-sensitive.
REQ-008 MSTP  in  1  monitor stop request, level.
REQ-009 MSTEP  in  1  monitor single-step request; rising edge counts.
REQ-010 STOP  out  1  high = timer held stopped.
REQ-011 GOJAM_  out  1  active-low machine-wide restart.
REQ-012 STOPA  out  1  high while in HOLD state (monitor stop acknowledged).
REQ-013 RSTCNT  out  CNT_W  count of restart sequences entered since reset.

Function
REQ-014 States: GOJAM, RUN, HOLD, STEP; all outputs registered, decoded from state.
REQ-015 GOSET = OR of the six restart causes; a GOSET pulse of any width >= 1 SIM_CLK is latched into GOPEND until the next EVNSET consumes it.
REQ-016 State transitions occur only on cycles with EVNSET=1; on other cycles state and GOJAM down-counter hold.
REQ-017 Priority at an EVNSET cycle: GOPEND (or GOSET) > MSTP/MSTEP handling > default.
REQ-018 Any state, EVNSET=1 and GOPEND=1: enter GOJAM, load down-counter with GOJAM_MCT-1, clear GOPEND, RSTCNT+1.
REQ-019 GOJAM: GOJAM_=0, STOP=1; each EVNSET decrements counter; at EVNSET with counter=0 and no GOPEND go to RUN.
REQ-020 A new restart cause during GOJAM reloads the counter (sequence restarts) and increments RSTCNT.
REQ-021 RUN: STOP=0, GOJAM_=1; at EVNSET with T12=1 and MSTP=1 go to HOLD.
REQ-022 HOLD: STOP=1, STOPA=1; at EVNSET with MSTP=0 go to RUN; else if STEPPEND=1 go to STEP and clear STEPPEND.
REQ-023 STEPPEND is set by a MSTEP rising edge (one-cycle-delayed sample) only while in HOLD; MSTEP edges in other states are discarded.
REQ-024 STEP: STOP=0, STOPA=0; at EVNSET with T12=1 go to HOLD if MSTP=1, else RUN.
REQ-025 MSTP asserted when T12 never occurs keeps RUN (stop only at instruction boundary).
REQ-026 RSTCNT saturates at all-ones; no wrap.
REQ-027 GOSET and EVNSET in the same cycle: GOPEND is treated as set for that cycle (restart taken immediately).

Reset
REQ-028 RESET_=0 asynchronously forces: state GOJAM, counter GOJAM_MCT-1, GOJAM_=0, STOP=1, STOPA=0, RSTCNT=0, GOPEND=0, STEPPEND=0, MSTEP sample=0.
REQ-029 After RESET_ deassertion the block completes a full GOJAM_MCT-strobe restart then enters RUN; reset does not increment RSTCNT.
REQ-030 RESET_ asserted mid-sequence (any state) aborts it and reapplies REQ-028 within the same cycle.

Verification
REQ-031 Release reset, EVNSET every 12 clocks, no causes -> GOJAM_=0 for 4 EVNSETs, then GOJAM_=1, STOP=0, RSTCNT=0.
REQ-032 In RUN, 1-cycle STRT1 pulse between EVNSETs -> at next EVNSET GOJAM_=0 for 4 EVNSETs, RSTCNT=1.
REQ-033 ALGA pulse on 2nd EVNSET of GOJAM -> counter reloaded, GOJAM_ low 4 further EVNSETs, RSTCNT=2.
REQ-034 MSTP=1 in RUN, T12=1 at 3rd EVNSET -> HOLD at that edge, STOP=1, STOPA=1; MSTEP pulse -> STEP at next EVNSET, STOP=0 until next T12 EVNSET, then HOLD.
REQ-035 HOLD, MSTP dropped and STRT2 pulsed before same EVNSET -> GOJAM taken, not RUN; RSTCNT increments.
REQ-036 Force 300 restarts with CNT_W=8 -> RSTCNT=255; RESET_ mid-STEP -> all outputs at REQ-028 values same cycle.
